// File: rtl/mips_trace_buffer.sv
// mips_trace_buffer
// Post-trigger trace capture for the single-cycle mips core. Once armed, the
// block waits for a programmable PC. When that PC appears it records a window
// of {pc, alu} samples, one per clock. The window is then drained in order
// through a valid/ready read port.
module mips_trace_buffer #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_arm,
  input  logic [31:0]   i_trig_pc,
  input  logic [AW:0]   i_capture_len,
  input  logic [31:0]   i_pc_in,
  input  logic [31:0]   i_alu_in,
  output logic [1:0]    o_state,
  output logic [AW:0]   o_count,
  output logic          o_rd_valid,
  input  logic          i_rd_ready,
  output logic [31:0]   o_rd_pc,
  output logic [31:0]   o_rd_alu,
  output logic          o_rd_last
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_ARMED   = 2'd1;
  localparam logic [1:0] S_CAPTURE = 2'd2;
  localparam logic [1:0] S_DRAIN   = 2'd3;

  localparam logic [AW:0]   DEPTH_LEN = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE   = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE   = AW'(1);

  logic [63:0]   r_mem [DEPTH];
  logic [1:0]    r_state;
  logic [AW-1:0] r_wp;
  logic [AW-1:0] r_rp;
  logic [AW:0]   r_count;
  logic [AW:0]   r_len;
  logic [31:0]   r_trig;

  logic [AW:0]   w_len_norm;
  logic [AW:0]   w_count_inc;
  logic          w_match;
  logic          w_wr_en;
  logic          w_rd_valid;
  logic          w_pop;
  logic [63:0]   w_head;

  // Normalise the requested length, decode the trigger and the read handshake
  always_comb begin
    w_len_norm  = ((i_capture_len == '0) || (i_capture_len > DEPTH_LEN)) ? DEPTH_LEN : i_capture_len;
    w_count_inc = r_count + CNT_ONE;
    w_match     = (r_state == S_ARMED) && (i_pc_in == r_trig);
    w_wr_en     = !i_rst && (w_match || (r_state == S_CAPTURE));
    w_rd_valid  = (r_state == S_DRAIN) && (r_count != '0);
    w_pop       = w_rd_valid && i_rd_ready;
    w_head      = r_mem[r_rp];
  end

  // Trace storage is deliberately not reset; only the pointers give it meaning
  always_ff @(posedge i_clk) begin
    if (w_wr_en) begin
      r_mem[r_wp] <= {i_pc_in, i_alu_in};
    end
  end

  // Capture/drain sequencer with pointer and occupancy bookkeeping
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_wp    <= '0;
      r_rp    <= '0;
      r_count <= '0;
      r_len   <= DEPTH_LEN;
      r_trig  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_arm) begin
            r_trig  <= i_trig_pc;
            r_len   <= w_len_norm;
            r_wp    <= '0;
            r_rp    <= '0;
            r_count <= '0;
            r_state <= S_ARMED;
          end
        end
        S_ARMED: begin
          if (w_match) begin
            r_wp    <= r_wp + PTR_ONE;
            r_count <= w_count_inc;
            r_state <= (r_len == CNT_ONE) ? S_DRAIN : S_CAPTURE;
          end
        end
        S_CAPTURE: begin
          r_wp    <= r_wp + PTR_ONE;
          r_count <= w_count_inc;
          if (w_count_inc == r_len) begin
            r_state <= S_DRAIN;
          end
        end
        default: begin
          if (w_pop) begin
            r_rp    <= r_rp + PTR_ONE;
            r_count <= r_count - CNT_ONE;
            if (r_count == CNT_ONE) begin
              r_state <= S_IDLE;
            end
          end
        end
      endcase
    end
  end

  // Read port drives zeros outside DRAIN so consumers never see X
  always_comb begin
    o_state    = r_state;
    o_count    = r_count;
    o_rd_valid = w_rd_valid;
    o_rd_last  = (r_state == S_DRAIN) && (r_count == CNT_ONE);
    o_rd_pc    = w_rd_valid ? w_head[63:32] : 32'd0;
    o_rd_alu   = w_rd_valid ? w_head[31:0]  : 32'd0;
  end

endmodule

// File: tb/tb_mips_trace_buffer.sv
// tb_mips_trace_buffer
// Drives a simple mips-like PC/ALU stream into the trace buffer. It checks a
// table of per-cycle vectors plus hand-written multi-cycle sequences. The
// expected trace entries are kept in a scoreboard queue.
module tb_mips_trace_buffer;

  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          arm;
  logic [31:0]   trigPc;
  logic [AW:0]   capLen;
  logic [31:0]   pcIn;
  logic [31:0]   aluIn;
  logic [1:0]    state;
  logic [AW:0]   count;
  logic          rdValid;
  logic          rdReady;
  logic [31:0]   rdPc;
  logic [31:0]   rdAlu;
  logic          rdLast;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] alu;
  } entry_t;

  typedef struct {
    logic        rst;
    logic        arm;
    logic [31:0] trig;
    logic [AW:0] len;
    logic        rdy;
    logic [1:0]  st;
    logic [AW:0] cnt;
    logic        vld;
    logic        lst;
    logic [31:0] pc;
    logic [31:0] alu;
  } vec_t;

  entry_t      sb[$];
  vec_t        vecs[$];
  int          nVectors = 0;
  int          nMiscompares = 0;
  int          popCount = 0;
  logic [31:0] corePc = 32'd0;
  logic [1:0]  mState = 2'd0;
  logic [31:0] mTrig = 32'd0;
  int          mLen = DEPTH;
  int          mCap = 0;

  // Free-running clock
  always #5 clk = ~clk;

  mips_trace_buffer #(.DEPTH(DEPTH), .AW(AW)) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_arm         (arm),
    .i_trig_pc     (trigPc),
    .i_capture_len (capLen),
    .i_pc_in       (pcIn),
    .i_alu_in      (aluIn),
    .o_state       (state),
    .o_count       (count),
    .o_rd_valid    (rdValid),
    .i_rd_ready    (rdReady),
    .o_rd_pc       (rdPc),
    .o_rd_alu      (rdAlu),
    .o_rd_last     (rdLast)
  );

  // ALU result the core produces at each PC (memfile program for 0..C)
  function automatic logic [31:0] aluOf(input logic [31:0] pc);
    case (pc)
      32'h0:   aluOf = 32'd5;
      32'h4:   aluOf = 32'd10;
      32'h8:   aluOf = 32'd15;
      32'hC:   aluOf = 32'd4;
      default: aluOf = pc * 32'd3 + 32'h100;
    endcase
  endfunction

  function automatic vec_t mkVec(input logic r, input logic a, input logic [31:0] t,
                                 input logic [AW:0] l, input logic rdy, input logic [1:0] st,
                                 input logic [AW:0] cnt, input logic vl, input logic ls,
                                 input logic [31:0] pc, input logic [31:0] alu);
    vec_t v;
    v.rst = r; v.arm = a; v.trig = t; v.len = l; v.rdy = rdy;
    v.st = st; v.cnt = cnt; v.vld = vl; v.lst = ls; v.pc = pc; v.alu = alu;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    nVectors++;
    if (act !== exp) begin
      nMiscompares++;
      $display("[TB] FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  // One clock: drive inputs, advance the reference, clock, then check outputs
  task automatic applyStimulus(input logic r, input logic a, input logic [31:0] t,
                               input logic [AW:0] l, input logic rdy);
    entry_t e;
    logic   eV;
    rst = r; arm = a; trigPc = t; capLen = l; rdReady = rdy;
    pcIn = corePc; aluIn = aluOf(corePc);
    e.pc = corePc; e.alu = aluOf(corePc);
    if (r) begin
      mState = 2'd0; sb.delete(); mCap = 0;
    end else begin
      case (mState)
        2'd0: if (a) begin
          mTrig = t;
          mLen = ((l == 0) || (int'(l) > DEPTH)) ? DEPTH : int'(l);
          mCap = 0;
          mState = 2'd1;
        end
        2'd1: if (corePc == mTrig) begin
          sb.push_back(e); mCap = 1;
          mState = (mLen == 1) ? 2'd3 : 2'd2;
        end
        2'd2: begin
          sb.push_back(e); mCap++;
          if (mCap == mLen) mState = 2'd3;
        end
        default: if (rdy && sb.size() > 0) begin
          e = sb.pop_front();
          popCount++;
          checkOutput("pop.valid", rdValid, 1);
          checkOutput("pop.pc", rdPc, e.pc);
          checkOutput("pop.alu", rdAlu, e.alu);
          if (sb.size() == 0) mState = 2'd0;
        end
      endcase
    end
    @(posedge clk);
    #1;
    corePc = (corePc + 32'd4) & 32'hFF;
    eV = (mState == 2'd3) && (sb.size() > 0);
    checkOutput("model.state", state, mState);
    checkOutput("model.count", count, sb.size());
    checkOutput("model.valid", rdValid, eV);
    checkOutput("model.last", rdLast, (mState == 2'd3) && (sb.size() == 1));
    checkOutput("model.pc", rdPc, eV ? sb[0].pc : 32'd0);
    checkOutput("model.alu", rdAlu, eV ? sb[0].alu : 32'd0);
  endtask

  task automatic waitValid(input string name, input int budget);
    int n = 0;
    while (rdValid !== 1'b1 && n < budget) begin
      applyStimulus(0, 0, 0, 0, 0);
      n++;
    end
    checkOutput({name, ".validRise"}, rdValid, 1);
  endtask

  task automatic drainToIdle(input string name, input int budget);
    int n = 0;
    while (state !== 2'd0 && n < budget) begin
      applyStimulus(0, 0, 0, 0, 1);
      n++;
    end
    checkOutput({name, ".idle"}, state, 0);
  endtask

  // Watchdog in case a timing control ever blocks unexpectedly
  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got timeout, want completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Main test sequence
  initial begin
    int p0;
    rst = 1'b1; arm = 1'b0; trigPc = '0; capLen = '0; rdReady = 1'b0;
    pcIn = '0; aluIn = '0;
    applyStimulus(1, 0, 0, 0, 0);
    checkOutput("reset.state", state, 0);
    checkOutput("reset.count", count, 0);
    checkOutput("reset.valid", rdValid, 0);
    checkOutput("reset.pc", rdPc, 0);
    corePc = 32'd0;

    // Basic window: trigger 0x4, length 3
    vecs.push_back(mkVec(0, 1, 32'h4, 5'd3, 1, 2'd1, 5'd0, 0, 0, 32'h0, 32'h0));
    vecs.push_back(mkVec(0, 0, 32'h0, 5'd0, 1, 2'd2, 5'd1, 0, 0, 32'h0, 32'h0));
    vecs.push_back(mkVec(0, 0, 32'h0, 5'd0, 1, 2'd2, 5'd2, 0, 0, 32'h0, 32'h0));
    vecs.push_back(mkVec(0, 0, 32'h0, 5'd0, 1, 2'd3, 5'd3, 1, 0, 32'h4, 32'd10));
    vecs.push_back(mkVec(0, 0, 32'h0, 5'd0, 1, 2'd3, 5'd2, 1, 0, 32'h8, 32'd15));
    vecs.push_back(mkVec(0, 0, 32'h0, 5'd0, 1, 2'd3, 5'd1, 1, 1, 32'hC, 32'd4));
    vecs.push_back(mkVec(0, 0, 32'h0, 5'd0, 1, 2'd0, 5'd0, 0, 0, 32'h0, 32'h0));
    // Arm coinciding with a would-be match: only the arm takes effect
    vecs.push_back(mkVec(0, 1, 32'h1C, 5'd2, 0, 2'd1, 5'd0, 0, 0, 32'h0, 32'h0));
    vecs.push_back(mkVec(0, 0, 32'h0, 5'd0, 0, 2'd1, 5'd0, 0, 0, 32'h0, 32'h0));
    vecs.push_back(mkVec(1, 0, 32'h0, 5'd0, 0, 2'd0, 5'd0, 0, 0, 32'h0, 32'h0));
    // Length 1: ARMED goes straight to DRAIN, rd_last immediately
    vecs.push_back(mkVec(0, 1, 32'h2C, 5'd1, 0, 2'd1, 5'd0, 0, 0, 32'h0, 32'h0));
    vecs.push_back(mkVec(0, 0, 32'h0, 5'd0, 0, 2'd3, 5'd1, 1, 1, 32'h2C, 32'h184));
    vecs.push_back(mkVec(0, 0, 32'h0, 5'd0, 0, 2'd3, 5'd1, 1, 1, 32'h2C, 32'h184));
    vecs.push_back(mkVec(0, 0, 32'h0, 5'd0, 1, 2'd0, 5'd0, 0, 0, 32'h0, 32'h0));

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].rst, vecs[i].arm, vecs[i].trig, vecs[i].len, vecs[i].rdy);
      checkOutput($sformatf("vec%0d.state", i), state, vecs[i].st);
      checkOutput($sformatf("vec%0d.count", i), count, vecs[i].cnt);
      checkOutput($sformatf("vec%0d.valid", i), rdValid, vecs[i].vld);
      checkOutput($sformatf("vec%0d.last", i), rdLast, vecs[i].lst);
      checkOutput($sformatf("vec%0d.pc", i), rdPc, vecs[i].pc);
      checkOutput($sformatf("vec%0d.alu", i), rdAlu, vecs[i].alu);
    end

    // Back-pressure: head and count hold while rd_ready is low
    applyStimulus(1, 0, 0, 0, 0);
    corePc = 32'd0;
    p0 = popCount;
    applyStimulus(0, 1, 32'h4, 5'd3, 0);
    waitValid("bp", 10);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(0, 0, 0, 0, 0);
      checkOutput("bp.holdPc", rdPc, 32'h4);
      checkOutput("bp.holdAlu", rdAlu, 32'd10);
      checkOutput("bp.holdCount", count, 3);
      checkOutput("bp.holdLast", rdLast, 0);
    end
    drainToIdle("bp", 10);
    checkOutput("bp.pops", popCount - p0, 3);

    // Full depth via length 0: count reaches 16 and the write pointer wraps
    applyStimulus(1, 0, 0, 0, 0);
    corePc = 32'h40;
    p0 = popCount;
    applyStimulus(0, 1, 32'h44, 5'd0, 0);
    waitValid("full", 30);
    checkOutput("full.count", count, 16);
    checkOutput("full.firstPc", rdPc, 32'h44);
    drainToIdle("full", 30);
    checkOutput("full.pops", popCount - p0, 16);

    // Oversized length clamps to DEPTH
    applyStimulus(1, 0, 0, 0, 0);
    corePc = 32'd0;
    applyStimulus(0, 1, 32'h8, 5'd20, 0);
    waitValid("clamp", 30);
    checkOutput("clamp.count", count, 16);
    drainToIdle("clamp", 30);

    // No trigger: stays ARMED, a second arm (even one that would match) is ignored
    applyStimulus(1, 0, 0, 0, 0);
    applyStimulus(0, 1, 32'hFFFF_FFFC, 5'd3, 1);
    for (int i = 0; i < 50; i++) begin
      if (i == 20) applyStimulus(0, 1, (corePc + 32'd4) & 32'hFF, 5'd2, 1);
      else         applyStimulus(0, 0, 0, 0, 1);
      checkOutput("notrig.state", state, 1);
      checkOutput("notrig.valid", rdValid, 0);
    end

    // Reset mid-capture, with a simultaneous arm that must be discarded
    applyStimulus(1, 0, 0, 0, 0);
    corePc = 32'd0;
    applyStimulus(0, 1, 32'h4, 5'd5, 0);
    for (int i = 0; i < 10 && count !== 5'd2; i++) applyStimulus(0, 0, 0, 0, 0);
    checkOutput("midrst.count2", count, 2);
    checkOutput("midrst.capture", state, 2);
    applyStimulus(1, 1, corePc, 5'd2, 0);
    checkOutput("midrst.state", state, 0);
    checkOutput("midrst.count", count, 0);
    checkOutput("midrst.valid", rdValid, 0);
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("midrst.noArm", state, 0);
    applyStimulus(0, 1, (corePc + 32'd8) & 32'hFF, 5'd2, 1);
    waitValid("rearm", 10);
    checkOutput("rearm.count", count, 2);
    drainToIdle("rearm", 10);

    // Arm pulsed during DRAIN is ignored
    applyStimulus(1, 0, 0, 0, 0);
    corePc = 32'd0;
    p0 = popCount;
    applyStimulus(0, 1, 32'h10, 5'd2, 0);
    waitValid("drainArm", 10);
    applyStimulus(0, 1, corePc, 5'd5, 0);
    checkOutput("drainArm.state", state, 3);
    checkOutput("drainArm.count", count, 2);
    drainToIdle("drainArm", 10);
    checkOutput("drainArm.pops", popCount - p0, 2);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(0, 0, 0, 0, 1);
      checkOutput("drainArm.stayIdle", state, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
    $finish;
  end

endmodule

// File: doc/mips_trace_buffer.md
# mips_trace_buffer

Post-trigger execution trace capture for the single-cycle `mips` core. It sits directly downstream of the core and samples the core's `pc_out` / `alu_result` pair every clock. Once armed and triggered on a programmable PC, it records a fixed-length window of samples. The window is then drained through a valid/ready read port to a bench monitor or a debug UART bridge.

## Interface
Parameters:
- `DEPTH`, 16: number of trace entries; must be a power of two, minimum 2.
- `AW`, 4: log2(`DEPTH`).

Ports:
- `clk`  in  1: rising-edge clock, same clock as the `mips` core.
- `rst`  in  1: synchronous reset, active-high. Sampled only on the rising edge of `clk`.
- `arm`  in  1: single-cycle request to start a capture. Honoured only in IDLE.
- `trig_pc`  in  32: PC value that starts capture.
- `capture_len`  in  AW+1: number of samples to record, 1..DEPTH. Value 0 means DEPTH. Values above DEPTH are clamped to DEPTH. Latched when `arm` is accepted.
- `pc_in`  in  32: connected to core `pc_out`.
- `alu_in`  in  32: connected to core `alu_result`.
- `state`  out  2: 0 = IDLE, 1 = ARMED, 2 = CAPTURE, 3 = DRAIN.
- `count`  out  AW+1: number of entries currently held.
- `rd_valid`  out  1: head entry is available.
- `rd_ready`  in  1: consumer accepts the head entry.
- `rd_pc`  out  32: PC of the head entry.
- `rd_alu`  out  32: ALU result of the head entry.
- `rd_last`  out  1: head entry is the final entry (`count` == 1 in DRAIN).

## Operation
- Storage: `DEPTH` x 64-bit array, written synchronously.
  - Write pointer `wp` and read pointer `rp` are AW bits wide and wrap modulo `DEPTH`.
  - `count` is AW+1 bits wide.
- IDLE:
  - `arm`=1 latches `trig_pc` and `capture_len` (normalised as above) and clears `wp`, `rp` and `count`.
  - Next state is ARMED.
- ARMED, when `pc_in` == latched trigger PC:
  - The sample {`pc_in`, `alu_in`} is written at `wp`; `wp` and `count` increment.
  - Next state is CAPTURE, or DRAIN if the latched length is 1.
- ARMED, no match: hold indefinitely. `arm` is ignored.
- CAPTURE:
  - One sample is written every cycle unconditionally.
  - On the edge where `count` reaches the latched length, next state is DRAIN.
  - `arm` is ignored.
- DRAIN:
  - `rd_valid` = 1 while `count` > 0.
  - `rd_pc` / `rd_alu` present the entry at `rp` (combinational read).
  - On a cycle with `rd_valid` & `rd_ready`, the entry is popped: `rp` increments and `count` decrements.
  - Popping the entry with `rd_last` = 1 returns the block to IDLE.
  - No new samples are written in DRAIN. `arm` is ignored.
- Outputs outside DRAIN: `rd_valid`, `rd_last` = 0. `rd_pc` / `rd_alu` are don't-care but must not be X in simulation; they drive 0.
- The trigger compare is a full 32-bit equality. No masking.

## Timing
- Reset values: `state`=IDLE, `count`=0, `rd_valid`=0, `rd_last`=0, `rd_pc`=0, `rd_alu`=0. Internal `wp`=`rp`=0 and latched length = DEPTH.
  - Array contents are not cleared.
- Reset mid-operation, in any state: the edge with `rst`=1 forces all of the above. Any `arm` in that same cycle is discarded.
- Capture latency:
  - The trigger-match sample is stored on the same edge that the match is seen.
  - For length L, the last sample is stored L-1 cycles later.
  - `rd_valid` rises the cycle after that edge.
- `arm` is accepted on edge N. The earliest sample that can match is the one present at edge N+1.
- Back-pressure: while `rd_valid`=1 and `rd_ready`=0, `rd_pc`, `rd_alu`, `rd_last` and `count` stay stable.
  - Throughput is one entry per cycle when `rd_ready` is held high.
- Full boundary: with L = DEPTH, `wp` wraps to 0 on the final write. `count` = DEPTH at entry to DRAIN, which is the maximum.
- `arm` and a trigger match in the same cycle while IDLE: only the arm takes effect. Matching starts next cycle.

## Test plan
- Basic window: `mips` runs the memfile program (PC 0,4,8,C with ALU 5,10,15,4). Stimulus: `arm` with `trig_pc`=0x4, `capture_len`=3, `rd_ready`=1.
  - Required: reads (0x4,10), (0x8,15), (0xC,4); `rd_last` only on the third read; `state` returns to 0.
- Back-pressure: same setup, but `rd_ready`=0 for 5 cycles after `rd_valid` rises.
  - Required: `rd_pc` holds 0x4 and `count` holds 3 throughout; the entries then drain in order.
- Length boundaries:
  - `capture_len`=1: exactly one entry, CAPTURE state is skipped, `rd_last`=1 immediately.
  - `capture_len`=0 with DEPTH=16: 16 consecutive PCs captured, `count` reaches 16, `wp` wraps.
- No trigger: `trig_pc`=0xFFFF_FFFC, never reached. Required: `state` stays 1 for 50 cycles; `rd_valid`=0; a second `arm` has no effect.
- Reset mid-capture: assert `rst` for one cycle while `count`=2 in CAPTURE.
  - Required: next cycle `state`=0, `count`=0, `rd_valid`=0; a fresh `arm` then works normally.
- Ignored arm: pulse `arm` during DRAIN. Required: the latched length is unchanged, the drain completes, and the block returns to IDLE with no re-arm.
